mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports listed clock first, then reset.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 cpu_req / cpu_wen  in  1 / 1  CPU access request / write (1) or read (0).
REQ-005 cpu_addr / cpu_wdata  in  9 / 32  CPU word address / write data.
REQ-006 cpu_gnt / cpu_rvalid  out  1 / 1  CPU access accepted this cycle / CPU read data valid.
REQ-007 cpu_rdata  out  32  CPU read data.
REQ-008 dbg_req / dbg_wen / dbg_lock  in  1 / 1 / 1  debug-loader request / write / hold ownership for a burst.
REQ-009 dbg_addr / dbg_wdata  in  9 / 32  debug word address / write data.
REQ-010 dbg_gnt / dbg_rvalid  out  1 / 1  debug access accepted / debug read data valid.
REQ-011 dbg_rdata  out  32  debug read data.
REQ-012 mem_en / mem_wen / mem_addr / mem_wdata  out  1 / 1 / 9 / 32  single-port 512x32 RAM command.
REQ-013 mem_rdata  in  32  RAM read data, valid one cycle after mem_en with mem_wen=0.
REQ-014 busy  out  1  high while in state LOCK or while any read is outstanding.

Function
REQ-015 Owner FSM states SHALL be: IDLE, CPU, DBG, LOCK; the state holds the last grantee for the fairness decision.
REQ-016 Grant SHALL be combinational from req, FSM state and the priority pointer; at most one gnt is high per cycle.
REQ-017 When gnt is high, the grantee's wen/addr/wdata SHALL drive mem_* in the same cycle, with mem_en=1.
REQ-018 When no gnt is high: mem_en=0, mem_wen=0, mem_addr=0, mem_wdata=0.
REQ-019 A requester SHALL hold req/wen/addr/wdata stable until it samples gnt=1; the access completes on that edge.
REQ-020 Read latency: rvalid SHALL pulse exactly one cycle after the granted read, with rdata=mem_rdata, routed to the original requester.
REQ-021 rdata SHALL hold its last value while rvalid=0.
REQ-022 Write: no rvalid is generated; data is in the RAM after the granting edge.
REQ-023 Both requesting: grant SHALL follow the arbitration policy of REQ-030/REQ-031.
REQ-024 dbg granted with dbg_lock=1: next state SHALL be LOCK; in LOCK, cpu_gnt=0 and dbg gets every cycle it requests, until dbg_lock=0, then IDLE.
REQ-025 A CPU request during LOCK SHALL stall (gnt=0) with no loss; it is granted the first cycle after LOCK exits.
REQ-026 A single requester SHALL be granted every cycle (back-to-back accesses at full throughput).
REQ-027 IDLE->CPU or IDLE->DBG on the respective grant; CPU/DBG->IDLE on a cycle with no grant.

Reset
REQ-028 Asserting rst SHALL immediately force: state=IDLE, pointer=CPU-first, rvalid=0, rdata=0, busy=0, and all gnt and mem_* outputs=0.
REQ-029 A read in flight at reset SHALL be discarded: no rvalid after release.

Configuration
REQ-030 With MEM_ARB_ROUND_ROBIN_EN defined, a conflict SHALL go to the requester not granted last; the pointer updates on every grant.
REQ-031 Without MEM_ARB_ROUND_ROBIN_EN, the CPU SHALL always win a conflict (fixed priority); LOCK behaviour is unchanged.

Structure
REQ-032 Package mem_arb_pkg SHALL hold ADDR_W=9, DATA_W=32 and the owner-state enum.
REQ-033 The block SHALL be a single module with no sub-module; fairness logic stays inline.

Verification
REQ-034 CPU write 0x1A5 <- 0xDEADBEEF, then read 0x1A5 -> cpu_gnt on both accesses; cpu_rvalid one cycle later with 0xDEADBEEF; dbg_rvalid stays 0.
REQ-035 Both requesting for 4 cycles (round robin, last grant CPU) -> grants in order DBG, CPU, DBG, CPU; fixed-priority build -> CPU in all 4 cycles.
REQ-036 dbg_lock=1 during 8 debug writes to 0x000..0x007 while cpu_req=1 -> cpu_gnt=0 for 8 cycles, busy=1; CPU is granted in the cycle after dbg_lock falls.
REQ-037 Debug read issued, rst asserted on the next edge -> no dbg_rvalid; all outputs 0 immediately.
REQ-038 Back-to-back CPU reads of 0x000 to 0x1FF -> 512 consecutive grants; address wraps with no gaps; rvalid every cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared widths and owner-state encoding for the CPU/debug RAM port arbiter.
// Imported by mem_port_arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CPU  = 2'd1,
        DBG  = 2'd2,
        LOCK = 2'd3
    } ownerState_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-master (CPU, debug loader) arbiter for a single-port 512x32 RAM.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin conflicts; default is CPU-first.
module mem_port_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dbg_req,
    input  logic              dbg_wen,
    input  logic              dbg_lock,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,

    output logic              mem_en,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    ownerState_t state;
    ownerState_t stateNext;

    logic cpuWins;
    logic cpuGntRaw;
    logic dbgGntRaw;

    logic cpuPend;
    logic dbgPend;
    logic [DATA_W-1:0] cpuRdataQ;
    logic [DATA_W-1:0] dbgRdataQ;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Set after a CPU grant so the next conflict goes to debug.
    logic dbgFirst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbgFirst <= 1'b0;
        end else if (cpu_gnt || dbg_gnt) begin
            dbgFirst <= cpu_gnt;
        end
    end

    assign cpuWins = !dbgFirst;
`else
    assign cpuWins = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            LOCK: begin
                stateNext = dbg_lock ? LOCK : IDLE;
            end
            default: begin
                if (dbg_gnt && dbg_lock) begin
                    stateNext = LOCK;
                end else if (cpu_gnt) begin
                    stateNext = CPU;
                end else if (dbg_gnt) begin
                    stateNext = DBG;
                end else begin
                    stateNext = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        cpuGntRaw = 1'b0;
        dbgGntRaw = 1'b0;
        unique case (state)
            LOCK: begin
                dbgGntRaw = dbg_req;
            end
            default: begin
                if (cpu_req && dbg_req) begin
                    cpuGntRaw = cpuWins;
                    dbgGntRaw = !cpuWins;
                end else begin
                    cpuGntRaw = cpu_req;
                    dbgGntRaw = dbg_req;
                end
            end
        endcase
    end

    // Reset must silence the grants even while requests are held high.
    assign cpu_gnt = cpuGntRaw & rst;
    assign dbg_gnt = dbgGntRaw & rst;

    always_comb begin
        mem_en    = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_en    = 1'b1;
            mem_wen   = cpu_wen;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_en    = 1'b1;
            mem_wen   = dbg_wen;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpuPend   <= 1'b0;
            dbgPend   <= 1'b0;
            cpuRdataQ <= '0;
            dbgRdataQ <= '0;
        end else begin
            cpuPend <= cpu_gnt & ~cpu_wen;
            dbgPend <= dbg_gnt & ~dbg_wen;
            if (cpuPend) begin
                cpuRdataQ <= mem_rdata;
            end
            if (dbgPend) begin
                dbgRdataQ <= mem_rdata;
            end
        end
    end

    // RAM data is live in the rvalid cycle; the copy holds it afterwards.
    assign cpu_rvalid = cpuPend;
    assign dbg_rvalid = dbgPend;
    assign cpu_rdata  = cpuPend ? mem_rdata : cpuRdataQ;
    assign dbg_rdata  = dbgPend ? mem_rdata : dbgRdataQ;

    assign busy = (state == LOCK) | cpuPend | dbgPend;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 512x32 RAM.
// Honours MEM_ARB_ROUND_ROBIN_EN for the conflict expectations.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_wen = 1'b0;
    logic [8:0]  cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dbg_req = 1'b0;
    logic        dbg_wen = 1'b0;
    logic        dbg_lock = 1'b0;
    logic [8:0]  dbg_addr = '0;
    logic [31:0] dbg_wdata = '0;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_en;
    logic        mem_wen;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        busy;

    int vecs = 0;
    int errs = 0;

    logic        ramClear = 1'b1;
    logic [31:0] ram [512];
    logic [31:0] expMem [512];

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam logic [3:0] CONFLICT_DBG = 4'b0101;
`else
    localparam logic [3:0] CONFLICT_DBG = 4'b0000;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wen(cpu_wen),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_wen(dbg_wen), .dbg_lock(dbg_lock),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    function automatic logic [31:0] pat(int i);
        return 32'h5A00_0000 + i * 32'h0001_0001;
    endfunction

    always @(posedge clk) begin
        if (ramClear) begin
            for (int i = 0; i < 512; i++) ram[i] <= pat(i);
        end else if (mem_en) begin
            if (mem_wen) ram[mem_addr] <= mem_wdata;
            else mem_rdata <= ram[mem_addr];
        end
    end

    task automatic test_reset();
        for (int i = 0; i < 512; i++) expMem[i] = pat(i);
        cpu_req = 1'b1; dbg_req = 1'b1; cpu_addr = 9'h155; cpu_wdata = 32'h1234_5678;
        @(negedge clk); #1;
        vecs++; if (cpu_gnt !== 1'b0) begin errs++; $display("FAIL rst_cpu_gnt got %b want 0", cpu_gnt); end
        vecs++; if (dbg_gnt !== 1'b0) begin errs++; $display("FAIL rst_dbg_gnt got %b want 0", dbg_gnt); end
        vecs++; if (mem_en !== 1'b0) begin errs++; $display("FAIL rst_mem_en got %b want 0", mem_en); end
        vecs++; if (mem_addr !== 9'h0) begin errs++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
        vecs++; if (mem_wdata !== 32'h0) begin errs++; $display("FAIL rst_mem_wdata got %h want 0", mem_wdata); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", busy); end
        vecs++; if ({cpu_rvalid, dbg_rvalid} !== 2'b00) begin errs++; $display("FAIL rst_rvalid got %b want 00", {cpu_rvalid, dbg_rvalid}); end
        vecs++; if (cpu_rdata !== 32'h0 || dbg_rdata !== 32'h0) begin errs++; $display("FAIL rst_rdata got %h/%h want 0/0", cpu_rdata, dbg_rdata); end
        @(negedge clk);
        cpu_req = 1'b0; dbg_req = 1'b0; ramClear = 1'b0; rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cpu_write_read();
        cpu_req = 1'b1; cpu_wen = 1'b1; cpu_addr = 9'h1A5; cpu_wdata = 32'hDEAD_BEEF;
        #1;
        vecs++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin errs++; $display("FAIL wr_gnt got %b%b want 10", cpu_gnt, dbg_gnt); end
        vecs++; if ({mem_en, mem_wen, mem_addr, mem_wdata} !== {1'b1, 1'b1, 9'h1A5, 32'hDEAD_BEEF}) begin
            errs++; $display("FAIL wr_mem got en%b wen%b %h %h want en1 wen1 1a5 deadbeef", mem_en, mem_wen, mem_addr, mem_wdata); end
        expMem[9'h1A5] = 32'hDEAD_BEEF;
        @(negedge clk);
        cpu_wen = 1'b0;
        #1;
        vecs++; if (cpu_gnt !== 1'b1 || mem_wen !== 1'b0) begin errs++; $display("FAIL rd_gnt got gnt%b wen%b want gnt1 wen0", cpu_gnt, mem_wen); end
        vecs++; if (cpu_rvalid !== 1'b0) begin errs++; $display("FAIL wr_no_rvalid got %b want 0", cpu_rvalid); end
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        vecs++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEAD_BEEF) begin errs++; $display("FAIL rd_data got v%b %h want v1 deadbeef", cpu_rvalid, cpu_rdata); end
        vecs++; if (dbg_rvalid !== 1'b0) begin errs++; $display("FAIL rd_dbg_rvalid got %b want 0", dbg_rvalid); end
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL rd_busy got %b want 1", busy); end
        vecs++; if (mem_en !== 1'b0 || mem_addr !== 9'h0) begin errs++; $display("FAIL idle_mem got en%b %h want en0 000", mem_en, mem_addr); end
        @(negedge clk); #1;
        vecs++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'hDEAD_BEEF) begin errs++; $display("FAIL rd_hold got v%b %h want v0 deadbeef", cpu_rvalid, cpu_rdata); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_conflict();
        logic [3:0] wantDbg;
        wantDbg = CONFLICT_DBG;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            cpu_req = (i < 4); cpu_wen = 1'b0; cpu_addr = 9'h010;
            dbg_req = (i < 4); dbg_wen = 1'b0; dbg_addr = 9'h020;
            #1;
            if (i < 4) begin
                vecs++; if ({cpu_gnt, dbg_gnt} !== {!wantDbg[i], wantDbg[i]}) begin
                    errs++; $display("FAIL conflict_gnt[%0d] got cpu%b dbg%b want cpu%b dbg%b", i, cpu_gnt, dbg_gnt, !wantDbg[i], wantDbg[i]); end
            end
            if (i > 0 && wantDbg[i-1]) begin
                vecs++; if ({dbg_rvalid, cpu_rvalid, dbg_rdata} !== {2'b10, expMem[9'h020]}) begin
                    errs++; $display("FAIL conflict_dbg_rd[%0d] got dv%b cv%b %h want dv1 cv0 %h", i, dbg_rvalid, cpu_rvalid, dbg_rdata, expMem[9'h020]); end
            end else if (i > 0) begin
                vecs++; if ({cpu_rvalid, dbg_rvalid, cpu_rdata} !== {2'b10, expMem[9'h010]}) begin
                    errs++; $display("FAIL conflict_cpu_rd[%0d] got cv%b dv%b %h want cv1 dv0 %h", i, cpu_rvalid, dbg_rvalid, cpu_rdata, expMem[9'h010]); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lock();
        for (int i = 0; i < 10; i++) begin
            dbg_req = (i < 8); dbg_lock = (i < 8); dbg_wen = 1'b1;
            dbg_addr = 9'(i); dbg_wdata = 32'hD000_0000 + 32'(i);
            cpu_req = (i >= 1); cpu_wen = 1'b0; cpu_addr = 9'h1A5;
            #1;
            if (i < 8) begin
                expMem[i] = 32'hD000_0000 + 32'(i);
                vecs++; if ({dbg_gnt, mem_addr, mem_wdata} !== {1'b1, 9'(i), 32'hD000_0000 + 32'(i)}) begin
                    errs++; $display("FAIL lock_dbg_wr[%0d] got g%b %h %h want g1 %h %h", i, dbg_gnt, mem_addr, mem_wdata, 9'(i), 32'hD000_0000 + 32'(i)); end
            end
            if (i >= 1 && i <= 8) begin
                vecs++; if (cpu_gnt !== 1'b0 || busy !== 1'b1) begin
                    errs++; $display("FAIL lock_stall[%0d] got cpu_gnt%b busy%b want cpu_gnt0 busy1", i, cpu_gnt, busy); end
            end
            if (i == 9) begin
                vecs++; if ({cpu_gnt, dbg_gnt, mem_addr, busy} !== {2'b10, 9'h1A5, 1'b0}) begin
                    errs++; $display("FAIL lock_exit got cpu%b dbg%b %h busy%b want cpu1 dbg0 1a5 busy0", cpu_gnt, dbg_gnt, mem_addr, busy); end
            end
            @(negedge clk);
        end
        cpu_req = 1'b0; dbg_wen = 1'b0;
        #1;
        vecs++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== expMem[9'h1A5]) begin
            errs++; $display("FAIL lock_cpu_rd got v%b %h want v1 %h", cpu_rvalid, cpu_rdata, expMem[9'h1A5]); end
        @(negedge clk);
    endtask

    task automatic test_reset_inflight();
        dbg_req = 1'b1; dbg_wen = 1'b0; dbg_addr = 9'h003;
        #1;
        vecs++; if (dbg_gnt !== 1'b1) begin errs++; $display("FAIL inflight_gnt got %b want 1", dbg_gnt); end
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        vecs++; if ({dbg_rvalid, dbg_gnt, mem_en, busy} !== 4'b0000) begin
            errs++; $display("FAIL inflight_rst_out got rv%b g%b en%b busy%b want 0000", dbg_rvalid, dbg_gnt, mem_en, busy); end
        vecs++; if (cpu_rdata !== 32'h0 || dbg_rdata !== 32'h0) begin
            errs++; $display("FAIL inflight_rst_rdata got %h/%h want 0/0", cpu_rdata, dbg_rdata); end
        @(negedge clk);
        dbg_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            vecs++; if (dbg_rvalid !== 1'b0 || busy !== 1'b0) begin
                errs++; $display("FAIL inflight_discard[%0d] got rv%b busy%b want 0 0", i, dbg_rvalid, busy); end
        end
        cpu_req = 1'b1; dbg_req = 1'b1; cpu_addr = 9'h010; dbg_addr = 9'h020;
        #1;
        vecs++; if ({cpu_gnt, dbg_gnt} !== 2'b10) begin
            errs++; $display("FAIL post_rst_ptr got cpu%b dbg%b want cpu1 dbg0", cpu_gnt, dbg_gnt); end
        @(negedge clk);
        cpu_req = 1'b0; dbg_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int gaps;
        int bad;
        gaps = 0; bad = 0;
        for (int k = 0; k <= 513; k++) begin
            cpu_req = (k <= 512); cpu_wen = 1'b0; cpu_addr = 9'(k);
            #1;
            if (k <= 512) begin
                vecs++; if (cpu_gnt !== 1'b1 || mem_addr !== 9'(k)) begin
                    errs++; gaps++;
                    if (gaps < 4) $display("FAIL b2b_gnt[%0d] got g%b %h want g1 %h", k, cpu_gnt, mem_addr, 9'(k)); end
            end
            if (k >= 1) begin
                vecs++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== expMem[9'(k - 1)]) begin
                    errs++; bad++;
                    if (bad < 4) $display("FAIL b2b_rd[%0d] got v%b %h want v1 %h", k - 1, cpu_rvalid, cpu_rdata, expMem[9'(k - 1)]); end
            end
            @(negedge clk);
        end
        cpu_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cpu_write_read();
        test_conflict();
        test_lock();
        test_reset_inflight();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
